// File: rtl/ladder_hpf_if.sv
// Sample/coefficient bus for the ladder high-pass filter.
// The master drives sample strobes; the slave (filter) returns results and status.
`default_nettype none

interface ladder_hpf_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic signed [W-1:0] in;
  logic        [W-1:0] g;
  logic        [W-1:0] res;
  logic signed [W-1:0] out;
  logic                out_valid;
  logic                busy;
  logic                dropped;

  modport master (output in_valid, in, g, res, input out, out_valid, busy, dropped);
  modport slave  (input in_valid, in, g, res, output out, out_valid, busy, dropped);
endinterface

`default_nettype wire

// File: rtl/ladder_hpf.sv
// Four-pole ladder high-pass filter; one shared signed multiplier, one multiply per cycle.
// Each accepted sample walks FB -> S1..S4 -> MIX, producing a result six edges after acceptance.
`default_nettype none

module ladder_hpf #(
  parameter int W = 16
) (
  input  logic        sample_clk,
  input  logic        rst,
  ladder_hpf_if.slave bus
);

  localparam int PW = 2*W + 2;
  localparam logic signed [PW-1:0] SAT_MAX = PW'(2**(W-1) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, FB, S1, S2, S3, S4, MIX} state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W-1:0];
    else                  return v[W-1:0];
  endfunction

  state_t              state_q;
  logic signed [W-1:0] in_q;
  logic        [W-1:0] g_q;
  logic        [W-1:0] res_q;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] a_q [4];
  logic signed [W-1:0] out_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                dropped_q;

  logic signed [W-1:0]  src;
  logic signed [W-1:0]  ak;
  logic signed [W:0]    diff;
  logic signed [W:0]    mul_a;
  logic signed [W:0]    mul_b;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0]  x_d;
  logic signed [W-1:0]  a_d;
  logic signed [W-1:0]  out_d;

  // Stage k filters toward the already-updated output of stage k-1 (stage 1 toward x).
  always_comb begin
    src = x_q;
    ak  = a_q[0];
    case (state_q)
      S2:      begin src = a_q[0]; ak = a_q[1]; end
      S3:      begin src = a_q[1]; ak = a_q[2]; end
      S4:      begin src = a_q[2]; ak = a_q[3]; end
      default: ;
    endcase
    diff  = (W+1)'(src) - (W+1)'(ak);
    mul_a = (state_q == FB) ? {1'b0, res_q} : {1'b0, g_q};
    mul_b = (state_q == FB) ? (W+1)'(a_q[3]) : diff;
    prod  = PW'(mul_a) * PW'(mul_b);
    x_d   = sat_w(PW'(in_q) - (prod >>> (W-2)));
    a_d   = sat_w(PW'(ak) + (prod >>> W));
    out_d = sat_w(PW'(x_q)
                  - (PW'(a_q[0]) <<< 2)
                  + (PW'(a_q[1]) <<< 2) + (PW'(a_q[1]) <<< 1)
                  - (PW'(a_q[2]) <<< 2)
                  + PW'(a_q[3]));
  end

  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_q        <= '0;
      g_q         <= '0;
      res_q       <= '0;
      x_q         <= '0;
      for (int i = 0; i < 4; i++) a_q[i] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      // Any strobe outside IDLE, including the MIX cycle, is discarded.
      dropped_q   <= bus.in_valid && (state_q != IDLE);
      case (state_q)
        IDLE: if (bus.in_valid) begin
          in_q    <= bus.in;
          g_q     <= bus.g;
          res_q   <= bus.res;
          busy_q  <= 1'b1;
          state_q <= FB;
        end
        FB:  begin x_q    <= x_d; state_q <= S1;  end
        S1:  begin a_q[0] <= a_d; state_q <= S2;  end
        S2:  begin a_q[1] <= a_d; state_q <= S3;  end
        S3:  begin a_q[2] <= a_d; state_q <= S4;  end
        S4:  begin a_q[3] <= a_d; state_q <= MIX; end
        MIX: begin
          out_q       <= out_d;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.dropped   = dropped_q;

endmodule

`default_nettype wire

// File: doc/ladder_hpf.md
LADDER_HPF -- requirements
Module: ladder_hpf

Interface
REQ-001 Parameter: W, 16, sample/coefficient width in bits.
REQ-002 sample_clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  one-cycle strobe; in/g/res are valid this cycle.
REQ-005 in  input  W  signed two's-complement input sample.
REQ-006 g  input  W  unsigned cutoff coefficient, Q0.W (0 = 0.0, 2^W-1 ~ 1.0).
REQ-007 res  input  W  unsigned resonance, Q2.(W-2) (0 to just under 4.0).
REQ-008 out  output  W  signed high-pass output sample, held between updates.
REQ-009 out_valid  output  1  one-cycle pulse when out updates.
REQ-010 busy  output  1  high while a sample is in process (FSM not IDLE).
REQ-011 dropped  output  1  one-cycle pulse when in_valid is ignored because busy.

Function
REQ-012 Four-pole ladder high-pass; all stages share one signed multiplier, one multiply per cycle.
REQ-013 FSM states: IDLE, FB, S1, S2, S3, S4, MIX; each non-IDLE state lasts exactly one cycle.
REQ-014 IDLE + in_valid: latch in, g, res; go to FB. Otherwise stay in IDLE.
REQ-015 FB: fb = (res * a4) >>> (W-2), using a4 from the previous sample; x = sat_W(in - fb); go to S1.
REQ-016 Sk (k=1..4): ak <= sat_W(ak + ((g * (srck - ak)) >>> W)); src1 = x, srck = a(k-1) (already updated this sample); S1 to S4 advance in order.
REQ-017 Operations are full precision before the shift: difference W+1 bits; g zero-extended to W+1 bits; product 2W+2 bits.
REQ-018 Shifts are arithmetic (floor toward minus infinity).
REQ-019 sat_W clamps to [-2^(W-1), 2^(W-1)-1].
REQ-020 MIX: out <= sat_W(x - 4*a1 + 6*a2 - 4*a3 + a4), evaluated in at least W+5 bits using updated a1..a4.
REQ-021 MIX: out_valid pulses the following cycle; go to IDLE.
REQ-022 Latency: in_valid accepted at edge N -> out and out_valid change at edge N+6.
REQ-023 Maximum throughput: one sample per 7 cycles.
REQ-024 in_valid in the same cycle as the return to IDLE is not accepted; it is dropped.
REQ-025 in_valid while busy: no effect on state or latched inputs; dropped pulses at the next edge.
REQ-026 busy is high from edge N+1 through edge N+6, inclusive.
REQ-027 out holds its value between out_valid pulses.
REQ-028 g = 0 freezes a1..a4 (out = x - mix of frozen states). res = 0 disables feedback.

Reset
REQ-029 rst has priority over all other inputs, in every state including mid-sample.
REQ-030 On rst: FSM -> IDLE; a1..a4, x, out and latched regs = 0; out_valid, busy and dropped = 0.
REQ-031 Reset mid-sample discards that sample: no out_valid pulse occurs for it.

Verification
REQ-032 Reset: after rst, hold 2 cycles -> out=0, out_valid=0, busy=0; a strobe with in=1000, g=0, res=0 -> out=1000 exactly 6 edges later, one-cycle out_valid.
REQ-033 DC step: from reset, g=0x8000, res=0, in=16384 -> a1..a4 = 8192/4096/2048/1024, out=1024; repeated samples -> |out| decays toward 0.
REQ-034 Saturation: from reset, g=0, res=0, in=-32768 -> out=-32768. Then in=32767 -> out=32767, no wrap.
REQ-035 Overrun: strobe at edge N, then again at N+3 -> dropped pulses once, output at N+6 matches the first sample only.
REQ-036 Back-to-back: strobe at N+6 (the return-to-IDLE cycle) -> dropped. Strobe at N+7 -> accepted.
REQ-037 Reset mid-op: strobe at N, rst at N+3 -> no out_valid, out=0; next strobe behaves as from reset. Plus a res=0xC000 sweep vs a bit-exact reference model.
